redirect_ctrl: RTL and testbench

Sequencer for the fetch unit's control-flow redirects. Collects jump requests from execute and trap requests from the exception logic, filters requests from squashed (stale-tag) instructions, and drives the fetch `NewPC` input as a single-cycle pulse. It keeps an epoch counter that mirrors the fetch tag, so downstream stages can discard wrong-path instructions. It sits between the execute/exception logic and the fetch unit.

---
 rtl/redirect_ctrl_pkg.sv | 24 ++
 rtl/redirect_ctrl_if.sv | 33 +++
 rtl/redirect_ctrl_sat_counter.sv | 33 +++
 rtl/redirect_ctrl.sv | 145 ++++++++++++++
 tb/tb_redirect_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/redirect_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | redirect_pkg                                                        |
// | Shared types and constants for the fetch redirect sequencer.        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package redirect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } redir_state_t;

  localparam int          TAG_W   = 4;
  localparam logic [31:0] ZERO_PC = 32'h0000_0000;

  // Fetch works on word-aligned addresses; low bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/redirect_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | redirect_ctrl_if                                                    |
// | Request/redirect bundle between execute/exception logic and fetch.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface redirect_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             jump_req;
  logic [31:0]      jump_target;
  logic [TAG_W-1:0] jump_tag;
  logic             trap_req;
  logic [31:0]      trap_vector;
  logic [TAG_W-1:0] trap_tag;
  logic [31:0]      NewPC;
  logic [TAG_W-1:0] epoch;
  logic             squash;
  logic             busy;
  logic             err_zero_target;
  logic [7:0]       stale_cnt;

  modport master (
    output jump_req, jump_target, jump_tag, trap_req, trap_vector, trap_tag,
    input  NewPC, epoch, squash, busy, err_zero_target, stale_cnt
  );

  modport slave (
    input  jump_req, jump_target, jump_tag, trap_req, trap_vector, trap_tag,
    output NewPC, epoch, squash, busy, err_zero_target, stale_cnt
  );
endinterface
`default_nettype wire

// File: rtl/redirect_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter                                                         |
// | 8-bit saturating up-counter with synchronous active-low clear.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sat_counter (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       inc,
  output logic [7:0] count
);
  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | redirect_ctrl                                                       |
// | Filters jump/trap requests by epoch and issues one-cycle NewPC      |
// | pulses to fetch, with a blanking window and one pending slot.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module redirect_ctrl
  import redirect_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter int TAG_W        = redirect_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  redirect_ctrl_if.slave   bus
);

  redir_state_t     state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TAG_W-1:0] epoch_q, epoch_d;
  logic [31:0]      newpc_q, newpc_d;
  logic             squash_q, squash_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_trap_q, pend_trap_d;
  logic [31:0]      pend_target_q, pend_target_d;

  logic             valid_jump, valid_trap, stale_hit;
  logic             sel_valid, sel_zero, accept, take;
  logic [31:0]      sel_target;
  logic             mrg_valid, mrg_trap;
  logic [31:0]      mrg_target;

  always_comb begin
    valid_jump = bus.jump_req && (bus.jump_tag == epoch_q);
    valid_trap = bus.trap_req && (bus.trap_tag == epoch_q);
    stale_hit  = (bus.jump_req && (bus.jump_tag != epoch_q)) ||
                 (bus.trap_req && (bus.trap_tag != epoch_q));
    sel_valid  = valid_trap || valid_jump;
    sel_target = align_pc(valid_trap ? bus.trap_vector : bus.jump_target);
    sel_zero   = (sel_target == ZERO_PC);
    accept     = sel_valid && !sel_zero;
    // Older request wins unless a trap arrives over a pending jump.
    take       = accept && (!pend_valid_q || (valid_trap && !pend_trap_q));
    mrg_valid  = pend_valid_q || accept;
    mrg_trap   = take ? valid_trap : pend_trap_q;
    mrg_target = take ? sel_target : pend_target_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epoch_d       = epoch_q;
    newpc_d       = ZERO_PC;
    squash_d      = 1'b0;
    err_d         = sel_valid && sel_zero;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ISSUE;
          newpc_d  = sel_target;
          squash_d = 1'b1;
          epoch_d  = epoch_q + TAG_W'(1);
        end
      end
      ISSUE: begin
        state_d       = SETTLE;
        cnt_d         = 3'(BLANK_CYCLES);
        pend_valid_d  = mrg_valid;
        pend_trap_d   = mrg_trap;
        pend_target_d = mrg_target;
      end
      SETTLE: begin
        cnt_d         = cnt_q - 3'd1;
        pend_valid_d  = mrg_valid;
        pend_trap_d   = mrg_trap;
        pend_target_d = mrg_target;
        if (cnt_q <= 3'd1) begin
          if (mrg_valid) begin
            state_d      = ISSUE;
            newpc_d      = mrg_target;
            squash_d     = 1'b1;
            epoch_d      = epoch_q + TAG_W'(1);
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      epoch_q       <= '0;
      newpc_q       <= ZERO_PC;
      squash_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= ZERO_PC;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      epoch_q       <= epoch_d;
      newpc_q       <= newpc_d;
      squash_q      <= squash_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end

  sat_counter u_stale_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (stale_hit),
    .count (bus.stale_cnt)
  );

  assign bus.NewPC           = newpc_q;
  assign bus.epoch           = epoch_q;
  assign bus.squash          = squash_q;
  assign bus.busy            = busy_q;
  assign bus.err_zero_target = err_q;

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_redirect_ctrl                                                    |
// | Directed self-checking bench for redirect_ctrl.                     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_redirect_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;
  logic [3:0] exp_epoch;

  redirect_ctrl_if #(.TAG_W(4)) bus ();

  redirect_ctrl #(.BLANK_CYCLES(2), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.jump_req    = 1'b0;
    bus.jump_target = 32'h0;
    bus.jump_tag    = 4'h0;
    bus.trap_req    = 1'b0;
    bus.trap_vector = 32'h0;
    bus.trap_tag    = 4'h0;
  endtask

  task automatic drive_jump(input logic [31:0] tgt, input logic [3:0] tag);
    bus.jump_req    = 1'b1;
    bus.jump_target = tgt;
    bus.jump_tag    = tag;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_newpc", bus.NewPC, 32'h0);
    chk("rst_epoch", 32'(bus.epoch), 32'h0);
    chk("rst_squash", 32'(bus.squash), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err_zero_target), 32'h0);
    chk("rst_stale", 32'(bus.stale_cnt), 32'h0);
    reset = 1'b1;
    tick();

    // Basic jump: pulse, epoch step, busy for BLANK_CYCLES+1 cycles.
    drive_jump(32'h100, 4'h0);
    tick();
    idle_inputs();
    chk("j1_newpc", bus.NewPC, 32'h100);
    chk("j1_squash", 32'(bus.squash), 32'h1);
    chk("j1_epoch", 32'(bus.epoch), 32'h1);
    chk("j1_busy0", 32'(bus.busy), 32'h1);
    tick();
    chk("j1_newpc_off", bus.NewPC, 32'h0);
    chk("j1_squash_off", 32'(bus.squash), 32'h0);
    chk("j1_busy1", 32'(bus.busy), 32'h1);
    tick();
    chk("j1_busy2", 32'(bus.busy), 32'h1);
    tick();
    chk("j1_busy3", 32'(bus.busy), 32'h0);

    // Stale single, then both stale on one cycle counts once.
    drive_jump(32'h500, 4'h3);
    tick();
    idle_inputs();
    chk("stale_newpc", bus.NewPC, 32'h0);
    chk("stale_cnt1", 32'(bus.stale_cnt), 32'h1);
    chk("stale_busy", 32'(bus.busy), 32'h0);
    drive_jump(32'h500, 4'h7);
    bus.trap_req = 1'b1; bus.trap_vector = 32'h900; bus.trap_tag = 4'h7;
    tick();
    idle_inputs();
    chk("stale_both", 32'(bus.stale_cnt), 32'h2);

    // Trap beats jump on the same cycle; losing jump not counted.
    drive_jump(32'h200, 4'h1);
    bus.trap_req = 1'b1; bus.trap_vector = 32'h80; bus.trap_tag = 4'h1;
    tick();
    idle_inputs();
    chk("prio_newpc", bus.NewPC, 32'h80);
    chk("prio_epoch", 32'(bus.epoch), 32'h2);
    chk("prio_stale", 32'(bus.stale_cnt), 32'h2);
    repeat (3) tick();

    // Jump captured during SETTLE issues 3 cycles after the first.
    drive_jump(32'h303, 4'h2);
    tick();
    idle_inputs();
    chk("pend_first", bus.NewPC, 32'h300);
    chk("pend_ep1", 32'(bus.epoch), 32'h3);
    tick();
    drive_jump(32'h400, 4'h3);
    tick();
    idle_inputs();
    chk("pend_gap", bus.NewPC, 32'h0);
    tick();
    chk("pend_second", bus.NewPC, 32'h400);
    chk("pend_sq", 32'(bus.squash), 32'h1);
    chk("pend_ep2", 32'(bus.epoch), 32'h4);
    repeat (3) tick();
    chk("pend_idle", 32'(bus.busy), 32'h0);

    // Target that aligns to zero is dropped with an error pulse.
    drive_jump(32'h2, 4'h4);
    tick();
    idle_inputs();
    chk("zero_err", 32'(bus.err_zero_target), 32'h1);
    chk("zero_newpc", bus.NewPC, 32'h0);
    chk("zero_epoch", 32'(bus.epoch), 32'h4);
    chk("zero_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("zero_err_off", 32'(bus.err_zero_target), 32'h0);

    // Walk epoch from 4 through 15 and wrap to 0.
    exp_epoch = 4'h4;
    for (int i = 0; i < 12; i++) begin
      drive_jump(32'h1000 + 32'(i) * 32'h10, exp_epoch);
      tick();
      idle_inputs();
      exp_epoch = exp_epoch + 4'h1;
      chk("wrap_newpc", bus.NewPC, 32'h1000 + 32'(i) * 32'h10);
      chk("wrap_epoch", 32'(bus.epoch), 32'(exp_epoch));
      repeat (3) tick();
    end
    chk("wrap_zero", 32'(bus.epoch), 32'h0);

    // Stale counter saturates.
    drive_jump(32'h700, 4'h9);
    repeat (260) tick();
    idle_inputs();
    chk("stale_sat", 32'(bus.stale_cnt), 32'hFF);

    // Reset during SETTLE with a pending jump.
    drive_jump(32'h500, 4'h0);
    tick();
    idle_inputs();
    chk("rs_first", bus.NewPC, 32'h500);
    tick();
    drive_jump(32'h600, 4'h1);
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_epoch", 32'(bus.epoch), 32'h0);
    chk("rs_busy", 32'(bus.busy), 32'h0);
    chk("rs_stale", 32'(bus.stale_cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rs_newpc", bus.NewPC, 32'h0);
      tick();
    end
    chk("rs_epoch_end", 32'(bus.epoch), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
